// File: rtl/sdram_port_arbiter.sv
// Two-client round-robin arbiter and command sequencer for one SDRAM controller port.
// Command follows the sampled request by 2 cycles; ack follows busy fall (write) or read_ready (read) by 1.
module sdram_port_arbiter #(
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 16,
  parameter int TIMEOUT_W = 12
) (
  input  logic              clk50,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        ack,
  output logic [1:0]        err,
  output logic [DATA_W-1:0] rdata_o,
  output logic [1:0]        grant,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_busy,
  input  logic              mem_read_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_ACCEPT   = 3'd2,
    S_DONE     = 3'd3,
    S_RDATA    = 3'd4,
    S_COMPLETE = 3'd5
  } state_t;

  localparam logic [TIMEOUT_W-1:0] WD_MAX = '1;
  localparam logic [TIMEOUT_W-1:0] WD_ONE = TIMEOUT_W'(1);

  state_t              state_q, state_d;
  logic [1:0]          grant_q, grant_d;
  logic                last_grant_q, last_grant_d;
  logic                dir_q, dir_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic                rd_seen_q, rd_seen_d;
  logic                timeout_q, timeout_d;
  logic                busy_last_q, busy_last_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic                pick1;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    dir_d        = dir_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    rd_seen_d    = rd_seen_q;
    timeout_d    = timeout_q;
    busy_last_d  = mem_busy;
    wd_d         = wd_q;
    pick1        = 1'b0;

    case (state_q)
      S_IDLE: begin
        wd_d        = '0;
        timeout_d   = 1'b0;
        rd_seen_d   = 1'b0;
        grant_d     = 2'b00;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        if (|req) begin
          // On a tie the client that was not served last wins.
          pick1   = (req == 2'b11) ? ~last_grant_q : req[1];
          grant_d = pick1 ? 2'b10 : 2'b01;
          dir_d   = pick1 ? we[1] : we[0];
          addr_d  = pick1 ? addr1 : addr0;
          wdata_d = pick1 ? wdata1 : wdata0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!mem_busy) begin
          mem_write_d = dir_q;
          mem_read_d  = ~dir_q;
          state_d     = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        if (mem_busy && !busy_last_q) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = S_DONE;
        end
        if (!dir_q && mem_read_ready) begin
          rdata_d   = mem_rdata;
          rd_seen_d = 1'b1;
        end
      end
      S_DONE: begin
        if (!dir_q && mem_read_ready) begin
          rdata_d   = mem_rdata;
          rd_seen_d = 1'b1;
        end
        if (!mem_busy) begin
          state_d = (dir_q || rd_seen_q || mem_read_ready) ? S_COMPLETE : S_RDATA;
        end
      end
      S_RDATA: begin
        if (mem_read_ready) begin
          rdata_d = mem_rdata;
          state_d = S_COMPLETE;
        end
      end
      S_COMPLETE: begin
        last_grant_d = grant_q[1];
        grant_d      = 2'b00;
        state_d      = S_IDLE;
      end
      default: begin
        state_d     = S_IDLE;
        grant_d     = 2'b00;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase

    // Watchdog overrides whatever the transfer states decided.
    if (state_q inside {S_ISSUE, S_ACCEPT, S_DONE, S_RDATA}) begin
      wd_d = wd_q + WD_ONE;
      if (wd_d == WD_MAX) begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        timeout_d   = 1'b1;
        rdata_d     = '0;
        state_d     = S_COMPLETE;
      end
    end
  end

  always_ff @(posedge clk50) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= 2'b00;
      last_grant_q <= 1'b1;
      dir_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      rd_seen_q    <= 1'b0;
      timeout_q    <= 1'b0;
      busy_last_q  <= 1'b0;
      wd_q         <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      dir_q        <= dir_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      rd_seen_q    <= rd_seen_d;
      timeout_q    <= timeout_d;
      busy_last_q  <= busy_last_d;
      wd_q         <= wd_d;
    end
  end

  assign ack       = (state_q == S_COMPLETE) ? grant_q : 2'b00;
  assign err       = (state_q == S_COMPLETE && timeout_q) ? grant_q : 2'b00;
  assign grant     = grant_q;
  assign rdata_o   = rdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign state     = state_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed scenarios plus randomized two-client traffic against a behavioural controller and memory model.
module tb_sdram_port_arbiter;
  logic        clk50 = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [1:0]  we = 2'b00;
  logic [23:0] addr0 = '0, addr1 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0;
  logic [1:0]  ack, err, grant;
  logic [15:0] rdata_o, mem_wdata, mem_rdata;
  logic [23:0] mem_addr;
  logic        mem_read, mem_write, mem_busy, mem_read_ready;
  logic [2:0]  state;

  logic        auto_ctrl = 1'b0;
  logic        a_busy = 1'b0, a_ready = 1'b0, man_busy = 1'b0, man_ready = 1'b0;
  logic [15:0] a_rdata = '0, man_rdata = '0;

  assign mem_busy       = auto_ctrl ? a_busy  : man_busy;
  assign mem_read_ready = auto_ctrl ? a_ready : man_ready;
  assign mem_rdata      = auto_ctrl ? a_rdata : man_rdata;

  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;
  logic [15:0] ctrl_mem [logic [23:0]];
  logic [15:0] ref_mem  [logic [23:0]];

  sdram_port_arbiter #(.ADDR_W(24), .DATA_W(16), .TIMEOUT_W(12)) dut (
    .clk50(clk50), .rst(rst), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack(ack), .err(err), .rdata_o(rdata_o), .grant(grant),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_busy(mem_busy), .mem_read_ready(mem_read_ready), .mem_rdata(mem_rdata),
    .state(state)
  );

  always #10 clk50 = ~clk50;
  always @(posedge clk50) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [15:0] dflt(input logic [23:0] a);
    return a[15:0] ^ 16'hA5C3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk50);
  endtask

  // Controller stand-in: accepts a command, goes busy for a while, returns read data early or late.
  always begin : ctrl_model
    logic [23:0] ca;
    logic [15:0] cd;
    logic        cw;
    @(negedge clk50);
    if (auto_ctrl && (mem_write || mem_read)) begin
      ca = mem_addr;
      cd = mem_wdata;
      cw = mem_write;
      if (cw) ctrl_mem[ca] = cd;
      repeat ($urandom_range(0, 2)) @(negedge clk50);
      a_busy = 1'b1;
      repeat ($urandom_range(1, 4)) @(negedge clk50);
      cd = cw ? cd : (ctrl_mem.exists(ca) ? ctrl_mem[ca] : dflt(ca));
      if (!cw && $urandom_range(0, 1) == 0) begin
        a_ready = 1'b1;
        a_rdata = cd;
        @(negedge clk50);
        a_ready = 1'b0;
        a_busy  = 1'b0;
      end else begin
        a_busy = 1'b0;
        if (!cw) begin
          repeat ($urandom_range(0, 3)) @(negedge clk50);
          a_ready = 1'b1;
          a_rdata = cd;
          @(negedge clk50);
          a_ready = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [1:0]  exp_g, prev_req, prev_grant;
    logic        prev_cmd;
    int          last_srv, k, g0, off, nacks, pulses;
    logic [23:0] ta [2];
    logic [15:0] td [2];
    logic        tw [2];

    // Reset state
    tick(2);
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_ack_err", 32'({ack, err}), 32'h0);
    chk("rst_cmds", 32'({mem_read, mem_write}), 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_rdata", 32'(rdata_o), 32'h0);
    rst = 1'b0;

    // T1: client 0 write, busy for 3 cycles
    req = 2'b01; we = 2'b01; addr0 = 24'h000010; wdata0 = 16'h7FFF;
    tick(1);
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_state_issue", 32'(state), 32'h1);
    chk("t1_no_cmd_yet", 32'(mem_write), 32'h0);
    tick(1);
    chk("t1_write", 32'(mem_write), 32'h1);
    chk("t1_no_read", 32'(mem_read), 32'h0);
    chk("t1_addr", 32'(mem_addr), 32'h10);
    chk("t1_wdata", 32'(mem_wdata), 32'h7FFF);
    man_busy = 1'b1;
    tick(1);
    chk("t1_cmd_dropped", 32'(mem_write), 32'h0);
    chk("t1_state_done", 32'(state), 32'h3);
    tick(2);
    chk("t1_no_early_ack", 32'(ack), 32'h0);
    man_busy = 1'b0;
    tick(1);
    chk("t1_ack", 32'(ack), 32'h1);
    chk("t1_err", 32'(err), 32'h0);
    req = 2'b00;
    tick(1);
    chk("t1_grant_cleared", 32'(grant), 32'h0);
    chk("t1_idle", 32'(state), 32'h0);

    // T2: client 1 read through the wait-for-data path
    req = 2'b10; we = 2'b00; addr1 = 24'h800005;
    tick(1);
    chk("t2_grant", 32'(grant), 32'h2);
    tick(1);
    chk("t2_read", 32'({mem_read, mem_write}), 32'h2);
    chk("t2_addr", 32'(mem_addr), 32'h800005);
    man_busy = 1'b1;
    tick(1);
    chk("t2_cmd_dropped", 32'(mem_read), 32'h0);
    man_busy = 1'b0;
    tick(1);
    chk("t2_state_rdata", 32'(state), 32'h4);
    man_ready = 1'b1; man_rdata = 16'h8001;
    tick(1);
    chk("t2_ack", 32'(ack), 32'h2);
    chk("t2_rdata", 32'(rdata_o), 32'h8001);
    man_ready = 1'b0; req = 2'b00;
    tick(1);

    // T3: both clients request continuously; order must alternate starting with 0
    auto_ctrl = 1'b1;
    req = 2'b11; we = 2'b11; addr0 = 24'h000100; addr1 = 24'h000200;
    wdata0 = 16'($urandom); wdata1 = 16'($urandom);
    k = 0;
    for (int i = 0; i < 400 && k < 6; i++) begin
      tick(1);
      chk("t3_onehot", 32'($countones(ack) <= 1 && $countones(grant) <= 1), 32'h1);
      if (ack != 2'b00) begin
        chk("t3_order", 32'(ack), (k % 2 == 0) ? 32'h1 : 32'h2);
        k++;
        if (k == 6) req = 2'b00;
      end
    end
    chk("t3_count", 32'(k), 32'h6);
    auto_ctrl = 1'b0;
    tick(2);

    // T4: controller hangs busy; watchdog must end the transfer with err
    req = 2'b01; we = 2'b01; addr0 = 24'h000020; wdata0 = 16'h1234;
    tick(1);
    chk("t4_grant", 32'(grant), 32'h1);
    g0 = cyc_cnt;
    tick(1);
    chk("t4_write", 32'(mem_write), 32'h1);
    man_busy = 1'b1;
    for (int i = 0; i < 5000 && ack == 2'b00; i++) tick(1);
    off = cyc_cnt - g0;
    checks++;
    assert (off >= 4095 && off <= 4096) else begin
      failures++;
      $error("FAIL t4_latency observed=%0d expected=4095..4096", off);
    end
    chk("t4_ack", 32'(ack), 32'h1);
    chk("t4_err", 32'(err), 32'h1);
    chk("t4_cmds_low", 32'({mem_read, mem_write}), 32'h0);
    chk("t4_rdata_zero", 32'(rdata_o), 32'h0);
    req = 2'b00;
    if (off < 5001) tick(5001 - off);
    chk("t4_idle_while_busy", 32'({state, mem_read, mem_write}), 32'h0);
    man_busy = 1'b0;
    tick(1);

    // T5: reset while a read command is outstanding
    req = 2'b10; we = 2'b00; addr1 = 24'h000040;
    tick(1);
    chk("t5_grant1", 32'(grant), 32'h2);
    tick(1);
    chk("t5_accept", 32'({state, mem_read}), 32'h5);
    rst = 1'b1;
    tick(1);
    chk("t5_rst_state", 32'(state), 32'h0);
    chk("t5_rst_outs", 32'({ack, err, grant, mem_read, mem_write}), 32'h0);
    chk("t5_rst_data", 32'({mem_addr, mem_wdata}), 32'h0);
    rst = 1'b0;
    req = 2'b11; we = 2'b00; addr0 = 24'h000050; addr1 = 24'h000060;
    auto_ctrl = 1'b1;
    tick(1);
    chk("t5_client0_wins", 32'(grant), 32'h1);
    k = 0;
    for (int i = 0; i < 200 && k < 2; i++) begin
      tick(1);
      if (ack != 2'b00) begin
        chk("t5_order", 32'(ack), (k == 0) ? 32'h1 : 32'h2);
        chk("t5_rdata", 32'(rdata_o), 32'(dflt((k == 0) ? 24'h000050 : 24'h000060)));
        req = req & ~ack;
        k++;
      end
    end
    chk("t5_count", 32'(k), 32'h2);
    auto_ctrl = 1'b0;
    tick(2);

    // T6: controller busy at grant time; command must wait, then pulse once
    man_busy = 1'b1;
    req = 2'b01; we = 2'b01; addr0 = 24'h000030; wdata0 = 16'h0F0F;
    tick(1);
    chk("t6_grant", 32'(grant), 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("t6_withheld", 32'({mem_read, mem_write}), 32'h0);
    end
    man_busy = 1'b0;
    tick(1);
    chk("t6_write", 32'(mem_write), 32'h1);
    man_busy = 1'b1;
    tick(1);
    chk("t6_single", 32'(mem_write), 32'h0);
    man_busy = 1'b0;
    tick(1);
    chk("t6_ack", 32'(ack), 32'h1);
    chk("t6_no_reissue", 32'(mem_write), 32'h0);
    req = 2'b00;
    tick(1);

    // Randomized traffic against the reference memory and round-robin rule
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    auto_ctrl = 1'b1;
    last_srv = 1; prev_req = 2'b00; prev_grant = 2'b00; prev_cmd = 1'b0;
    pulses = 0; nacks = 0;
    for (int c = 0; c < 2; c++) begin
      tw[c] = 1'b0; ta[c] = '0; td[c] = '0;
    end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick(1);
      chk("rnd_cmd_excl", 32'(mem_read && mem_write), 32'h0);
      chk("rnd_onehot", 32'($countones(ack) <= 1 && $countones(grant) <= 1), 32'h1);
      if ((mem_read || mem_write) && !prev_cmd) pulses++;
      prev_cmd = mem_read || mem_write;
      if (grant != 2'b00 && prev_grant == 2'b00) begin
        exp_g = (prev_req == 2'b11) ? ((last_srv == 0) ? 2'b10 : 2'b01) : prev_req;
        chk("rnd_rr_grant", 32'(grant), 32'(exp_g));
      end
      prev_grant = grant;
      for (int c = 0; c < 2; c++) begin
        if (ack[c]) begin
          chk("rnd_ack_req", 32'(req[c]), 32'h1);
          chk("rnd_ack_grant", 32'(grant[c]), 32'h1);
          chk("rnd_err", 32'(err), 32'h0);
          chk("rnd_one_cmd", 32'(pulses), 32'h1);
          pulses = 0;
          if (tw[c]) ref_mem[ta[c]] = td[c];
          else chk("rnd_rdata", 32'(rdata_o),
                   32'(ref_mem.exists(ta[c]) ? ref_mem[ta[c]] : dflt(ta[c])));
          last_srv = c;
          nacks++;
          req[c] = 1'b0;
        end
      end
      if (cyc < 3000) begin
        for (int c = 0; c < 2; c++) begin
          if (!req[c] && $urandom_range(0, 2) == 0) begin
            tw[c]  = 1'($urandom_range(0, 1));
            ta[c]  = ($urandom_range(0, 1) == 1 ? 24'hFFFFF8 : 24'h000400) + 24'($urandom_range(0, 7));
            td[c]  = 16'($urandom);
            req[c] = 1'b1;
          end
        end
      end
      we = {tw[1], tw[0]};
      addr0 = ta[0]; addr1 = ta[1];
      wdata0 = td[0]; wdata1 = td[1];
      prev_req = req;
    end
    chk("rnd_drained", 32'(req), 32'h0);
    chk("rnd_activity", 32'(nacks > 100), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
